// File: rtl/bus_recovery_pkg.sv
// bus_recovery_pkg
//   Shared definitions for the bus timeout recovery controller:
//   - recovery_state_e : FSM state encoding
//   - DEFAULT_*        : default values for the controller parameters
//   - backoff_delay()  : backoff length for a given (1-based) retry index
package bus_recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ABORT   = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_FATAL   = 3'd5
  } recovery_state_e;

  localparam int DEFAULT_MAX_RETRIES  = 32'sd3;
  localparam int DEFAULT_BACKOFF_BASE = 32'sd2;

  // Backoff doubles with each retry: base, 2*base, 4*base, ...
  // retry_idx is 1 for the first retry.
  function automatic int backoff_delay(input int base, input int retry_idx);
    if (retry_idx < 32'sd1) begin
      return base;
    end else begin
      return base << (retry_idx - 32'sd1);
    end
  endfunction

endpackage

// File: rtl/bus_backoff_timer.sv
// bus_backoff_timer
//   Load / count-down timer used to space out retries. Only instantiated
//   when BUS_RECOVERY_BACKOFF_EN is defined.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset
//   load     in   load load_val into the counter (has priority over counting)
//   load_val in   W-bit delay in cycles (>= 1)
//   expired  out  high during the last cycle of the loaded delay
module bus_backoff_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  localparam logic [W-1:0] CNT_ONE  = W'(32'd1);
  localparam logic [W-1:0] CNT_ZERO = W'(32'd0);

  logic [W-1:0] cnt_r;

  // Countdown register: reload on request, otherwise step toward zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // A loaded value of N gives N cycles in the waiting state; the last of them
  // is the one where the counter reads 1. Zero also reads as expired so a
  // stray zero load can never stall the controller.
  assign expired = (cnt_r <= CNT_ONE);

endmodule

// File: rtl/bus_timeout_recovery.sv
// bus_timeout_recovery
//   Retry controller downstream of the bus watchdog. Issues each attempt as a
//   start_transaction pulse, aborts and retries on timeout_error up to
//   MAX_RETRIES times, then parks in a sticky fatal state until err_clear.
//   Keeps a saturating count of counted timeouts.
// Configuration macro:
//   BUS_RECOVERY_BACKOFF_EN - when defined, a BACKOFF wait of
//   BACKOFF_BASE << (retry-1) cycles is inserted between ABORT and ISSUE.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid / req_ready upstream request handshake (ready only in IDLE)
//   start_transaction     one-cycle pulse per attempt (bus and watchdog)
//   complete_transaction  bus completion (honoured only in WAIT)
//   timeout_error         watchdog timeout (honoured only in WAIT)
//   abort                 one-cycle pulse: drop the outstanding transfer
//   done_ok               one-cycle pulse after a successful completion
//   fatal_error           sticky until err_clear or reset
//   err_clear             leaves FATAL
//   retry_count           retries taken for the current request
//   timeout_total         saturating count of counted timeouts
module bus_timeout_recovery
  import bus_recovery_pkg::*;
#(
  parameter int MAX_RETRIES  = DEFAULT_MAX_RETRIES,
  parameter int BACKOFF_BASE = DEFAULT_BACKOFF_BASE,
  parameter int CNT_W        = 32'sd8,
  localparam int RC_W        = (MAX_RETRIES + 1 > 1) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             start_transaction,
  input  logic             complete_transaction,
  input  logic             timeout_error,
  output logic             abort,
  output logic             done_ok,
  output logic             fatal_error,
  input  logic             err_clear,
  output logic [RC_W-1:0]  retry_count,
  output logic [CNT_W-1:0] timeout_total
);

  localparam logic [RC_W-1:0]  RC_ZERO  = RC_W'(32'd0);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(32'd1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] TT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] TT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] TT_SAT   = {CNT_W{1'b1}};

  recovery_state_e  state_r;
  recovery_state_e  state_s;
  logic             done_ok_r;
  logic [RC_W-1:0]  retry_count_r;
  logic [RC_W-1:0]  retry_count_s;
  logic [CNT_W-1:0] timeout_total_r;
  logic             timeout_hit_s;

  // Completion wins over a simultaneous timeout, so such a timeout never counts.
  assign timeout_hit_s = (state_r == ST_WAIT) && timeout_error && !complete_transaction;

`ifdef BUS_RECOVERY_BACKOFF_EN
  localparam int MAX_DELAY = backoff_delay(BACKOFF_BASE, MAX_RETRIES);
  localparam int TMR_W     = $clog2(MAX_DELAY + 1);

  logic             backoff_load_s;
  logic [TMR_W-1:0] backoff_val_s;
  logic             backoff_done_s;

  // Loaded while in ABORT, where retry_count still holds the pre-increment
  // value, so the upcoming retry index is retry_count + 1.
  assign backoff_load_s = (state_r == ST_ABORT);
  assign backoff_val_s  = TMR_W'(backoff_delay(BACKOFF_BASE, int'(retry_count_r) + 32'sd1));

  bus_backoff_timer #(
    .W (TMR_W)
  ) u_backoff_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (backoff_load_s),
    .load_val (backoff_val_s),
    .expired  (backoff_done_s)
  );
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (complete_transaction) begin
          state_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          if (retry_count_r == RC_LAST) begin
            state_s = ST_FATAL;
          end else begin
            state_s = ST_ABORT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ABORT: begin
`ifdef BUS_RECOVERY_BACKOFF_EN
        state_s = ST_BACKOFF;
`else
        state_s = ST_ISSUE;
`endif
      end
      ST_BACKOFF: begin
`ifdef BUS_RECOVERY_BACKOFF_EN
        if (backoff_done_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_BACKOFF;
        end
`else
        state_s = ST_ISSUE;
`endif
      end
      ST_FATAL: begin
        if (err_clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FATAL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Retry counter next value: cleared on a new request or on leaving FATAL,
  // bumped once per abort.
  always_comb begin
    retry_count_s = retry_count_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          retry_count_s = RC_ZERO;
        end else begin
          retry_count_s = retry_count_r;
        end
      end
      ST_ABORT: begin
        retry_count_s = retry_count_r + RC_ONE;
      end
      ST_FATAL: begin
        if (err_clear) begin
          retry_count_s = RC_ZERO;
        end else begin
          retry_count_s = retry_count_r;
        end
      end
      default: begin
        retry_count_s = retry_count_r;
      end
    endcase
  end

  // Status registers: done pulse, retry count and saturating timeout total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_ok_r       <= 1'b0;
      retry_count_r   <= RC_ZERO;
      timeout_total_r <= TT_ZERO;
    end else begin
      done_ok_r     <= (state_r == ST_WAIT) && complete_transaction;
      retry_count_r <= retry_count_s;
      if (timeout_hit_s && (timeout_total_r != TT_SAT)) begin
        timeout_total_r <= timeout_total_r + TT_ONE;
      end
    end
  end

  // Every output is a state decode or a flop; no input reaches an output
  // combinationally.
  assign req_ready         = (state_r == ST_IDLE);
  assign start_transaction = (state_r == ST_ISSUE);
  assign abort             = (state_r == ST_ABORT);
  assign fatal_error       = (state_r == ST_FATAL);
  assign done_ok           = done_ok_r;
  assign retry_count       = retry_count_r;
  assign timeout_total     = timeout_total_r;

endmodule

// File: doc/bus_timeout_recovery.md
# bus_timeout_recovery

Retry controller that sits directly downstream of the bus watchdog timer and consumes its `timeout_error`. It issues each transaction as a `start_transaction` pulse, which drives both the bus and the watchdog. On timeout it aborts the outstanding transfer and retries up to `MAX_RETRIES` times, then escalates to a sticky fatal error. It also keeps a saturating count of all timeout events for status readback.

## Interface
- `MAX_RETRIES`, default 3: retries allowed after the first attempt (total attempts = `MAX_RETRIES+1`); must be ≥1
- `BACKOFF_BASE`, default 2: backoff length in cycles before the first retry (used only with `BUS_RECOVERY_BACKOFF_EN`); must be ≥1
- `CNT_W`, default 8: width of `timeout_total`
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  upstream request; accepted when `req_valid && req_ready`
- `req_ready`  out  1  high only in IDLE
- `start_transaction`  out  1  one-cycle pulse per attempt, to bus and watchdog
- `complete_transaction`  in  1  bus completion
- `timeout_error`  in  1  from watchdog
- `abort`  out  1  one-cycle pulse telling the bus to drop the outstanding transfer
- `done_ok`  out  1  one-cycle pulse on successful completion
- `fatal_error`  out  1  sticky; cleared only by `err_clear` or reset
- `err_clear`  in  1  clears FATAL
- `retry_count`  out  `$clog2(MAX_RETRIES+1)`  retries taken for the current request
- `timeout_total`  out  `CNT_W`  saturating count of accepted timeout events

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, ABORT, BACKOFF, FATAL.
- **IDLE:** `req_ready=1`. On accept: `retry_count<=0`, go to ISSUE.
- **ISSUE:** `start_transaction=1` for exactly one cycle, then go to WAIT.
- **WAIT, completion:**
  - `complete_transaction` → IDLE; `done_ok` pulses on the following cycle.
  - `complete_transaction` wins over a simultaneous `timeout_error`; that timeout is not counted.
- **WAIT, timeout:** `timeout_error` alone → `timeout_total` +1, saturating at all-ones. Then:
  - if `retry_count==MAX_RETRIES` → FATAL;
  - otherwise → ABORT.
- **ABORT:** `abort=1` for one cycle and `retry_count<=retry_count+1`. Next state is BACKOFF if the macro is defined, otherwise ISSUE.
- **BACKOFF:** wait `BACKOFF_BASE << (retry_count-1)` cycles, then go to ISSUE.
- **FATAL:** `fatal_error=1`, `req_ready=0`. `err_clear` → IDLE with `retry_count<=0`. `timeout_total` is retained.
- **Ignored inputs:**
  - `complete_transaction` and `timeout_error` outside WAIT, including late completions in ABORT or BACKOFF;
  - `err_clear` outside FATAL;
  - `req_valid` when `req_ready=0`.
- **Reset mid-operation:** return to IDLE immediately; any outstanding transfer is abandoned with no `abort` pulse.

## Timing
- All outputs are registered or decoded from state flops; there are no combinational input-to-output paths.
- **Reset values:**
  - `req_ready=1`;
  - `start_transaction=0`, `abort=0`, `done_ok=0`, `fatal_error=0`;
  - `retry_count=0`, `timeout_total=0`.
- **Request to start:** request accepted at edge N → `start_transaction` high in cycle N+1.
- **Completion:** `complete_transaction` sampled at edge C → `done_ok` high in cycle C+1 and `req_ready` high in cycle C+1.
- **Timeout, no backoff:** `timeout_error` at edge T → `abort` in T+1, `start_transaction` in T+2.
- **Timeout, with backoff:** `abort` in T+1, then BACKOFF for D cycles, then `start_transaction` in cycle T+2+D.
- **Fatal:** final timeout at edge T → `fatal_error` high from T+1.
- **Clearing fatal:** `err_clear` at edge E → `fatal_error` low and `req_ready` high from E+1.

## Configuration
- **`BUS_RECOVERY_BACKOFF_EN` defined:**
  - the BACKOFF state and backoff timer are compiled in;
  - the timer width is sized to hold `BACKOFF_BASE << (MAX_RETRIES-1)`;
  - delays are BASE, 2·BASE, 4·BASE, ….
- **`BUS_RECOVERY_BACKOFF_EN` undefined:**
  - BACKOFF is unreachable and no timer logic is generated;
  - ABORT goes directly to ISSUE;
  - `BACKOFF_BASE` is ignored.

## Structure
- **Package `bus_recovery_pkg`:**
  - state enum `recovery_state_e`;
  - default constants for `MAX_RETRIES` and `BACKOFF_BASE`;
  - a function returning the backoff delay for a given retry index.
- **Sub-module `bus_backoff_timer`:** load/count-down timer with `load`, `load_val` and `expired` ports. Instantiated only under `BUS_RECOVERY_BACKOFF_EN`.

## Test plan
Unless noted, benches use `MAX_RETRIES=2`, `BACKOFF_BASE=2`, macro defined.
- **Clean completion:** request accepted, `complete_transaction` 3 cycles after `start_transaction` → one `start_transaction`, one `done_ok`, `retry_count=0`, `timeout_total=0`.
- **Single retry:** first attempt times out, second completes → `abort` once, 2-cycle BACKOFF, second `start_transaction` at T+4, `done_ok`, `retry_count=1`, `timeout_total=1`.
- **Escalation to fatal:** all 3 attempts time out → backoffs of 2 then 4 cycles, `fatal_error=1`, `req_ready=0`, `timeout_total=3`. Then `err_clear` → IDLE, `fatal_error=0`.
- **Simultaneous events:** `complete_transaction` and `timeout_error` in the same WAIT cycle → `done_ok`, no `abort`, `timeout_total` unchanged. A late `complete_transaction` during BACKOFF is ignored.
- **Saturation:** `CNT_W=2`, 5 timeouts across requests → `timeout_total` holds at 3.
- **Async reset:** `reset` asserted mid-BACKOFF → outputs at reset values immediately, FSM in IDLE. Repeat with the macro undefined → `start_transaction` at T+2, no BACKOFF cycles.
